instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Programming-side writer for the rewritable instruction memory. Receives a byte stream from the UART receiver and decodes a header (start address, word count) plus payload. Assembles 32-bit words and drives the memory's write port (address, data, enable) one word at a time. Holds the core in reset while a load is in progress and releases it when the load completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: idle cycles between bytes, inside a session, before the session is aborted.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- rx_data_i  input  8  received byte.
- rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid this cycle.
- write_addr_o  output  32  byte address for the instruction memory write port.
- write_data_o  output  32  word for the instruction memory write port.
- write_enable_o  output  1  one-cycle write pulse.
- core_reset_o  output  1  high while a session is in progress; drives the core's reset.
- done_o  output  1  one-cycle pulse on successful completion of a session.
- error_o  output  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, ADDR, LEN, DATA.
- IDLE:
  - A byte with rx_valid_i moves the FSM to ADDR; that byte is address byte 0.
  - core_reset_o rises in the next cycle.
- ADDR: collects 4 bytes, MSB first, into base_addr, then moves to LEN.
- LEN: collects 4 bytes, MSB first, into word_cnt.
  - If word_cnt == 0: return to IDLE, pulse done_o, perform no writes.
  - Otherwise: move to DATA.
- DATA: collects bytes little-endian; the first byte goes to bits [7:0], the fourth to bits [31:24].
  - On the 4th byte of word k: write_data_o = word, write_addr_o = base_addr + 4*k, write_enable_o pulses.
  - After word word_cnt−1 is written: return to IDLE and pulse done_o in the same cycle as that write_enable_o.
- Address arithmetic is 32-bit and wraps modulo 2^32.
  - base_addr is used as given; the low 2 bits are not masked (the memory ignores them).
- Byte counter: 2 bits, reset to 0 on every state change.
- Word counter: 32 bits, cleared on entry to DATA.
- core_reset_o = 1 in ADDR, LEN and DATA; 0 in IDLE.
- Timeout:
  - The idle counter runs in ADDR, LEN and DATA and clears on every rx_valid_i.
  - When it reaches TIMEOUT_CYCLES−1 with no byte: return to IDLE, pulse error_o, no further writes. Words already written remain in memory.
  - A byte arriving in the same cycle the counter would expire is accepted; no timeout occurs.
- The counter is held at 0 in IDLE; no timeout occurs in IDLE.
- After done_o or error_o, the next byte starts a new session.

## Timing
- Reset values (asynchronous, on rst_ni low): state IDLE, write_addr_o 0, write_data_o 0, write_enable_o 0, core_reset_o 0, done_o 0, error_o 0, all counters 0.
- All outputs are registered.
- write_enable_o, write_addr_o and write_data_o change in the cycle after the rx_valid_i edge that delivers the word's 4th byte.
  - write_addr_o and write_data_o hold their values until the next write.
- core_reset_o:
  - rises 1 cycle after the first header byte;
  - falls 1 cycle after the final data byte, together with done_o.
- Back-to-back rx_valid_i on consecutive cycles is supported; the block sustains one write per 4 cycles.
- rst_ni asserted mid-session: immediate return to IDLE; core_reset_o drops; a partially assembled word is discarded and not written.

## Test plan
- Nominal load:
  - Stimulus: bytes 00 00 00 10 | 00 00 00 02 | 13 05 10 00 | 6F 00 00 00.
  - Required: writes (0x10, 0x00100513) then (0x14, 0x0000006F); done_o pulses with the second write; core_reset_o is high from after byte 1 until that cycle.
- Zero length:
  - Stimulus: header with address 0x0, count 0.
  - Required: no write_enable_o; done_o 1 cycle after the 8th byte; core_reset_o low again.
- Address wrap:
  - Stimulus: base 0xFFFFFFFC, count 2.
  - Required: write addresses 0xFFFFFFFC then 0x00000000.
- Timeout:
  - Setup: TIMEOUT_CYCLES = 16.
  - Stimulus: full header with count 1, then 2 data bytes, then silence.
  - Required: error_o pulses 16 cycles after the last byte; no write; state returns to IDLE.
  - Edge case: a byte arriving on cycle 15 is accepted and no error occurs.
- Reset mid-load:
  - Stimulus: rst_ni pulsed low after the 10th byte.
  - Required: all outputs 0 immediately; a fresh session afterwards writes correctly from its own base address.
- Back-to-back sessions:
  - Stimulus: a second header starts on the cycle right after done_o.
  - Required: core_reset_o re-asserts; second-session writes land at the new base.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Loads the rewritable instruction memory from a UART byte stream.
// Stream format: 4-byte base address, then a 4-byte word count (both MSB first), then little-endian words.
module instr_mem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [31:0] write_addr_o,
    output logic [31:0] write_data_o,
    output logic        write_enable_o,
    output logic        core_reset_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [31:0]   base_addr;
    logic [31:0]   word_cnt;
    logic [31:0]   word_idx;
    logic [23:0]   word_buf;
    logic [TW-1:0] idle_cnt;
    logic [31:0]   len_next;
    logic          expire;

    assign len_next = {word_cnt[23:0], rx_data_i};
    // A byte landing on the last idle cycle wins over the timeout.
    assign expire   = (state != IDLE) && !rx_valid_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            byte_cnt       <= 2'd0;
            base_addr      <= 32'd0;
            word_cnt       <= 32'd0;
            word_idx       <= 32'd0;
            word_buf       <= 24'd0;
            idle_cnt       <= '0;
            write_addr_o   <= 32'd0;
            write_data_o   <= 32'd0;
            write_enable_o <= 1'b0;
            core_reset_o   <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            write_enable_o <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;

            if (state == IDLE || rx_valid_i)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TW'(1);

            if (expire) begin
                state        <= IDLE;
                byte_cnt     <= 2'd0;
                idle_cnt     <= '0;
                core_reset_o <= 1'b0;
                error_o      <= 1'b1;
            end else if (rx_valid_i) begin
                case (state)
                    IDLE: begin
                        // The opening byte is already address byte 0.
                        state        <= ADDR;
                        base_addr    <= {24'd0, rx_data_i};
                        byte_cnt     <= 2'd1;
                        core_reset_o <= 1'b1;
                    end
                    ADDR: begin
                        base_addr <= {base_addr[23:0], rx_data_i};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= LEN;
                            byte_cnt <= 2'd0;
                        end
                    end
                    LEN: begin
                        word_cnt <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= 2'd0;
                            word_idx <= 32'd0;
                            if (len_next == 32'd0) begin
                                state        <= IDLE;
                                core_reset_o <= 1'b0;
                                done_o       <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data_i;
                            2'd1: word_buf[15:8]  <= rx_data_i;
                            2'd2: word_buf[23:16] <= rx_data_i;
                            2'd3: begin
                                write_data_o   <= {rx_data_i, word_buf};
                                write_addr_o   <= base_addr + (word_idx << 2);
                                write_enable_o <= 1'b1;
                                word_idx       <= word_idx + 32'd1;
                                if (word_idx == word_cnt - 32'd1) begin
                                    state        <= IDLE;
                                    byte_cnt     <= 2'd0;
                                    core_reset_o <= 1'b0;
                                    done_o       <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives byte streams into instr_mem_loader and compares every cycle against a stream-level model.
module tb_instr_mem_loader;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [31:0] write_addr, write_data;
    logic        write_enable, core_reset, done, error;

    always #5 clk = ~clk;

    instr_mem_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .write_addr_o(write_addr), .write_data_o(write_data), .write_enable_o(write_enable),
        .core_reset_o(core_reset), .done_o(done), .error_o(error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // stream: byte values and idle cycles preceding each byte
    logic [7:0]  sb[$];
    int          sg[$];
    bit          rnd_gaps = 1'b0;

    // expectations indexed by cycle (sample taken just after edge k)
    bit          e_we[], e_done[], e_err[], e_cr[];
    logic [31:0] e_addr[], e_data[];
    int          tt[];
    int          last_t;

    logic [31:0] wa_q[$], wd_q[$];
    int          err_k, done_k;

    function automatic int rgap();
        int r;
        if (!rnd_gaps) return 0;
        r = $urandom_range(0, 19);
        if (r < 13) return 0;
        if (r < 17) return $urandom_range(1, 4);
        if (r < 19) return T - 1;
        return T;
    endfunction

    task automatic add_byte(input logic [7:0] b, input int g);
        sb.push_back(b);
        sg.push_back(g);
    endtask

    task automatic add_hdr(input logic [31:0] base, input logic [31:0] cnt, input int g0);
        add_byte(base[31:24], g0);
        add_byte(base[23:16], rgap());
        add_byte(base[15:8],  rgap());
        add_byte(base[7:0],   rgap());
        add_byte(cnt[31:24],  rgap());
        add_byte(cnt[23:16],  rgap());
        add_byte(cnt[15:8],   rgap());
        add_byte(cnt[7:0],    rgap());
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) add_byte(w[8*i +: 8], rgap());
    endtask

    task automatic clear_stream();
        sb.delete();
        sg.delete();
    endtask

    task automatic close_sess(input int s, input int tc, input bit is_err);
        if (is_err) e_err[tc] = 1'b1;
        else        e_done[tc] = 1'b1;
        for (int k = s; k < tc; k++) e_cr[k] = 1'b1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_addr", write_addr, 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Model: parse the stream as sessions; a gap of more than T cycles between
    // captured bytes inside a session aborts it T cycles after the last byte.
    task automatic run_stream(input int stop_after);
        int n, t, endc, lim, pos, last, start, bi, idx;
        bit open;
        logic [31:0] base, cnt, word, a, d;
        n = sb.size();
        tt = new[n];
        t = 0;
        for (int i = 0; i < n; i++) begin
            t += 1 + sg[i];
            tt[i] = t;
        end
        last_t = t;
        endc = t + T + 4;
        e_we = new[endc + 1]; e_done = new[endc + 1]; e_err = new[endc + 1]; e_cr = new[endc + 1];
        e_addr = new[endc + 1]; e_data = new[endc + 1];
        open = 1'b0; pos = 0; last = 0; start = 0;
        base = 32'd0; cnt = 32'd0; word = 32'd0;
        for (int i = 0; i < n; i++) begin
            t = tt[i];
            if (open && (t - last) > T) begin
                close_sess(start, last + T, 1'b1);
                open = 1'b0;
            end
            if (!open) begin
                open = 1'b1; pos = 0; start = t;
            end
            last = t;
            if (pos < 4)      base = {base[23:0], sb[i]};
            else if (pos < 8) cnt  = {cnt[23:0], sb[i]};
            else              word[8*((pos - 8) % 4) +: 8] = sb[i];
            if (pos == 7 && cnt == 32'd0) begin
                close_sess(start, t, 1'b0);
                open = 1'b0;
            end else if (pos >= 8 && (pos - 8) % 4 == 3) begin
                idx = (pos - 8) / 4;
                e_we[t] = 1'b1;
                e_addr[t] = base + 32'(4 * idx);
                e_data[t] = word;
                if (32'(idx) == cnt - 32'd1) begin
                    close_sess(start, t, 1'b0);
                    open = 1'b0;
                end
            end
            pos++;
        end
        if (open) close_sess(start, last + T, 1'b1);
        a = 32'd0; d = 32'd0;
        for (int k = 0; k <= endc; k++) begin
            if (e_we[k]) begin a = e_addr[k]; d = e_data[k]; end
            e_addr[k] = a; e_data[k] = d;
        end

        lim = (stop_after > 0) ? tt[stop_after - 1] : endc;
        err_k = -1; done_k = -1; bi = 0;
        wa_q.delete(); wd_q.delete();
        for (int k = 1; k <= lim; k++) begin
            if (bi < n && tt[bi] == k) begin
                rx_valid = 1'b1; rx_data = sb[bi]; bi++;
            end else begin
                rx_valid = 1'b0; rx_data = 8'($urandom);
            end
            @(posedge clk);
            #1;
            chk($sformatf("we@%0d", k), 32'(write_enable), 32'(e_we[k]));
            chk($sformatf("done@%0d", k), 32'(done), 32'(e_done[k]));
            chk($sformatf("err@%0d", k), 32'(error), 32'(e_err[k]));
            chk($sformatf("core_reset@%0d", k), 32'(core_reset), 32'(e_cr[k]));
            chk($sformatf("addr@%0d", k), write_addr, e_addr[k]);
            chk($sformatf("data@%0d", k), write_data, e_data[k]);
            if (write_enable) begin wa_q.push_back(write_addr); wd_q.push_back(write_data); end
            if (error) err_k = k;
            if (done)  done_k = k;
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        #2;
        // nominal load
        do_reset();
        clear_stream();
        add_hdr(32'h10, 32'd2, 0);
        add_word(32'h0010_0513);
        add_word(32'h0000_006F);
        run_stream(0);
        chk("nom_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("nom_a0", wa_q[0], 32'h10);
            chk("nom_d0", wd_q[0], 32'h0010_0513);
            chk("nom_a1", wa_q[1], 32'h14);
            chk("nom_d1", wd_q[1], 32'h0000_006F);
        end
        chk("nom_done_k", 32'(done_k), 32'(last_t));

        // zero length
        do_reset();
        clear_stream();
        add_hdr(32'h0, 32'd0, 0);
        run_stream(0);
        chk("zero_nwr", 32'(wa_q.size()), 32'd0);
        chk("zero_done_k", 32'(done_k), 32'd8);
        chk("zero_core_reset", 32'(core_reset), 32'd0);

        // address wrap
        do_reset();
        clear_stream();
        add_hdr(32'hFFFF_FFFC, 32'd2, 0);
        add_word($urandom);
        add_word($urandom);
        run_stream(0);
        chk("wrap_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("wrap_a0", wa_q[0], 32'hFFFF_FFFC);
            chk("wrap_a1", wa_q[1], 32'h0);
        end

        // timeout after two data bytes
        do_reset();
        clear_stream();
        add_hdr(32'h100, 32'd1, 0);
        add_byte(8'hAA, 0);
        add_byte(8'hBB, 0);
        run_stream(0);
        chk("to_delay", 32'(err_k - last_t), 32'd16);
        chk("to_nwr", 32'(wa_q.size()), 32'd0);
        chk("to_core_reset", 32'(core_reset), 32'd0);

        // byte on the last idle cycle is accepted
        do_reset();
        clear_stream();
        add_hdr(32'h200, 32'd1, 0);
        add_byte(8'h11, 0);
        add_byte(8'h22, 0);
        add_byte(8'h33, T - 1);
        add_byte(8'h44, 0);
        run_stream(0);
        chk("edge_err_k", 32'(err_k), 32'hFFFF_FFFF);
        chk("edge_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("edge_a", wa_q[0], 32'h200);
            chk("edge_d", wd_q[0], 32'h4433_2211);
        end

        // reset mid-load, then a fresh session
        do_reset();
        clear_stream();
        add_hdr(32'h40, 32'd2, 0);
        add_word(32'hDEAD_BEEF);
        add_word(32'h1234_5678);
        run_stream(10);
        chk("mid_core_reset_pre", 32'(core_reset), 32'd1);
        do_reset();
        clear_stream();
        add_hdr(32'h80, 32'd1, 0);
        add_word(32'hCAFE_F00D);
        run_stream(0);
        chk("mid_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("mid_a", wa_q[0], 32'h80);
            chk("mid_d", wd_q[0], 32'hCAFE_F00D);
        end

        // back-to-back sessions
        do_reset();
        clear_stream();
        add_hdr(32'h1000, 32'd1, 0);
        add_word(32'h0000_0001);
        add_hdr(32'h2000, 32'd1, 0);
        add_word(32'h0000_0002);
        run_stream(0);
        chk("b2b_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("b2b_a0", wa_q[0], 32'h1000);
            chk("b2b_a1", wa_q[1], 32'h2000);
        end

        // randomized streams with random gaps, timeouts and wraps
        for (int r = 0; r < 10; r++) begin
            int ns;
            do_reset();
            clear_stream();
            rnd_gaps = 1'b1;
            ns = $urandom_range(1, 3);
            for (int s = 0; s < ns; s++) begin
                logic [31:0] base, cnt;
                base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
                cnt = 32'($urandom_range(0, 3));
                add_hdr(base, cnt, $urandom_range(0, 3));
                for (int w = 0; w < int'(cnt); w++) add_word($urandom);
            end
            rnd_gaps = 1'b0;
            run_stream(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
